// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with sign correction and fast paths for divide corner cases.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNTW = $clog2(WIDTH + 1);
    localparam int unsigned PW   = 2 * WIDTH;
    localparam logic [CNTW-1:0]  LAST_ITER = CNTW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SMIN      = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Operand decode at accept time
    logic             signed_a, signed_b, sa, sb, neg_in, fast;
    logic             b_zero, div_ovf;
    logic [WIDTH-1:0] abs_a, abs_b, fast_res;

    always_comb begin
        signed_a = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
        signed_b = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa       = signed_a & a[WIDTH-1];
        sb       = signed_b & b[WIDTH-1];
        abs_a    = sa ? -a : a;
        abs_b    = sb ? -b : b;
        // REM takes the sign of the dividend; everything else follows sign(a)^sign(b)
        neg_in   = (op[2] & op[1]) ? sa : (sa ^ sb);
        b_zero   = (b == '0);
        div_ovf  = ~op[0] & (a == SMIN) & (&b);
        fast     = op[2] & (b_zero | div_ovf);
        if (b_zero) fast_res = op[1] ? a : '1;
        else        fast_res = op[1] ? '0 : a;
    end

    // One iteration of each datapath
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;
    logic [PW-1:0]    prod, prod_fix;
    logic [WIDTH-1:0] q_fix, r_fix, calc_res;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi    = mul_sum[WIDTH:1];
        mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[WIDTH];
        div_hi    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo    = {lo_q[WIDTH-2:0], div_ge};
        prod      = {mul_hi, mul_lo};
        prod_fix  = neg_q ? -prod : prod;
        q_fix     = neg_q ? -div_lo : div_lo;
        r_fix     = neg_q ? -div_hi : div_hi;
        case (op_q)
            3'b000:                calc_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod_fix[PW-1:WIDTH];
            3'b100, 3'b101:        calc_res = q_fix;
            default:               calc_res = r_fix;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start && !flush) begin
                    op_d  = op;
                    neg_d = neg_in;
                    if (fast) begin
                        state_d  = S_DONE;
                        result_d = fast_res;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = op[2] ? abs_a : abs_b;
                        opnd_d  = op[2] ? abs_b : abs_a;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = op_q[2] ? div_hi : mul_hi;
                    lo_d  = op_q[2] ? div_lo : mul_lo;
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d  = S_DONE;
                        result_d = calc_res;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
